// File: rtl/snk_vbus_pkg.sv
// Shared types and constants for the video bus arbiter.
// Slot kinds, slot phases and the round-robin CPU index helper.
package snk_vbus_pkg;

    localparam int MAX_CPU = 4;
    localparam int CPU_IW  = 2;

    typedef enum logic {
        SLOT_VID = 1'b0,
        SLOT_CPU = 1'b1
    } slot_kind_t;

    typedef enum logic {
        PH_SETUP  = 1'b0,
        PH_STROBE = 1'b1
    } phase_t;

    function automatic logic [CPU_IW-1:0] next_cpu_idx(input logic [CPU_IW-1:0] idx,
                                                       input int n_cpu);
        logic [CPU_IW-1:0] nxt;
        if (int'(idx) >= n_cpu - 1) begin
            nxt = {CPU_IW{1'b0}};
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/snk_vbus_slot_seq.sv
// Slot/phase/cpu-index sequencer advanced by cen; VID, CPU0, VID, CPU1, ...
// With SNK_VBUS_VBLANK_BURST_EN defined, VID slots are skipped while vblank is high.
module snk_vbus_slot_seq
    import snk_vbus_pkg::*;
#(
    parameter int N_CPU = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cen,
    input  logic              vblank,
    output slot_kind_t        slot_kind,
    output phase_t            phase,
    output logic [CPU_IW-1:0] cpu_idx,
    output slot_kind_t        slot_kind_nxt,
    output phase_t            phase_nxt,
    output logic [CPU_IW-1:0] cpu_idx_nxt
);

    slot_kind_t        slot_kind_q, slot_kind_d;
    phase_t            phase_q, phase_d;
    logic [CPU_IW-1:0] cpu_idx_q, cpu_idx_d;
    logic              burst_s;

`ifdef SNK_VBUS_VBLANK_BURST_EN
    assign burst_s = vblank;
`else
    assign burst_s = vblank & 1'b0;
`endif

    // Next slot position: SETUP->STROBE, then on to the following slot
    always_comb begin
        slot_kind_d = slot_kind_q;
        phase_d     = phase_q;
        cpu_idx_d   = cpu_idx_q;
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_STROBE;
            end
            PH_STROBE: begin
                phase_d = PH_SETUP;
                case (slot_kind_q)
                    SLOT_VID: begin
                        slot_kind_d = SLOT_CPU;
                    end
                    SLOT_CPU: begin
                        cpu_idx_d = next_cpu_idx(cpu_idx_q, N_CPU);
                        if (burst_s) begin
                            slot_kind_d = SLOT_CPU;
                        end else begin
                            slot_kind_d = SLOT_VID;
                        end
                    end
                    default: begin
                        slot_kind_d = SLOT_VID;
                    end
                endcase
            end
            default: begin
                phase_d = PH_SETUP;
            end
        endcase
    end

    // Sequencer state, stepping only on cen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_kind_q <= SLOT_VID;
            phase_q     <= PH_SETUP;
            cpu_idx_q   <= {CPU_IW{1'b0}};
        end else if (cen) begin
            slot_kind_q <= slot_kind_d;
            phase_q     <= phase_d;
            cpu_idx_q   <= cpu_idx_d;
        end
    end

    assign slot_kind     = slot_kind_q;
    assign phase         = phase_q;
    assign cpu_idx       = cpu_idx_q;
    assign slot_kind_nxt = slot_kind_d;
    assign phase_nxt     = phase_d;
    assign cpu_idx_nxt   = cpu_idx_d;

endmodule

// File: rtl/snk_vbus_arbiter.sv
// Time-slot arbiter for the shared VA/VD video bus between N_CPU masters and N_DEV RAMs.
// Optional vblank burst mode is enabled by defining SNK_VBUS_VBLANK_BURST_EN.
module snk_vbus_arbiter
    import snk_vbus_pkg::*;
#(
    parameter int N_CPU = 2,
    parameter int N_DEV = 3,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cen,
    input  logic                   vblank,
    input  logic [N_CPU-1:0]       cpu_req,
    input  logic [N_CPU-1:0]       cpu_we,
    input  logic [N_CPU*AW-1:0]    cpu_addr,
    input  logic [N_CPU*DW-1:0]    cpu_wdata,
    input  logic [N_CPU*N_DEV-1:0] cpu_cs,
    output logic [N_CPU-1:0]       cpu_ack,
    output logic [DW-1:0]          cpu_rdata,
    input  logic [N_DEV*DW-1:0]    dev_rdata,
    output logic [AW-1:0]          va,
    output logic [DW-1:0]          vd_out,
    output logic [N_DEV-1:0]       dev_csn,
    output logic                   vwe_n,
    output logic                   v_c
);

    localparam logic [DW-1:0]    DATA_IDLE = {DW{1'b1}};
    localparam logic [N_DEV-1:0] CSN_IDLE  = {N_DEV{1'b1}};

    slot_kind_t        slot_kind_s, slot_kind_nxt_s;
    phase_t            phase_s, phase_nxt_s;
    logic [CPU_IW-1:0] cpu_idx_s, cpu_idx_nxt_s;

    logic [AW-1:0]    va_q, va_d;
    logic [DW-1:0]    vd_out_q, vd_out_d;
    logic [N_DEV-1:0] dev_csn_q, dev_csn_d;
    logic             vwe_n_q, vwe_n_d;
    logic             v_c_q, v_c_d;
    logic [N_CPU-1:0] cpu_ack_q, cpu_ack_d;
    logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [N_CPU-1:0] armed_q, armed_d;
    logic             active_q, active_d;
    logic             we_lat_q, we_lat_d;
    logic [N_DEV-1:0] cs_lat_q, cs_lat_d;

    logic [N_CPU-1:0] ack_now_s;
    logic [N_DEV-1:0] cs_pick_s;
    logic [DW-1:0]    rd_sel_s;
    logic             grant_s;

    // Multi-hot selects resolve to the lowest-index device
    function automatic logic [N_DEV-1:0] lowest_onehot(input logic [N_DEV-1:0] v);
        logic [N_DEV-1:0] r;
        logic             found;
        r     = {N_DEV{1'b0}};
        found = 1'b0;
        for (int d = 0; d < N_DEV; d++) begin
            if (v[d] && !found) begin
                r[d]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    snk_vbus_slot_seq #(
        .N_CPU (N_CPU)
    ) u_slot_seq (
        .clk           (clk),
        .reset         (reset),
        .cen           (cen),
        .vblank        (vblank),
        .slot_kind     (slot_kind_s),
        .phase         (phase_s),
        .cpu_idx       (cpu_idx_s),
        .slot_kind_nxt (slot_kind_nxt_s),
        .phase_nxt     (phase_nxt_s),
        .cpu_idx_nxt   (cpu_idx_nxt_s)
    );

    assign cs_pick_s = lowest_onehot(cpu_cs[cpu_idx_nxt_s*N_DEV +: N_DEV]);
    assign grant_s   = cpu_req[cpu_idx_nxt_s] & armed_q[cpu_idx_nxt_s]
                       & ~ack_now_s[cpu_idx_nxt_s];

    // Read data mux over the latched (already one-hot) device select
    always_comb begin
        rd_sel_s = DATA_IDLE;
        for (int d = N_DEV - 1; d >= 0; d--) begin
            rd_sel_s = cs_lat_q[d] ? dev_rdata[d*DW +: DW] : rd_sel_s;
        end
    end

    // Access completing at the end of the current STROBE phase
    always_comb begin
        ack_now_s = {N_CPU{1'b0}};
        if (slot_kind_s == SLOT_CPU && phase_s == PH_STROBE && active_q) begin
            ack_now_s[cpu_idx_s] = 1'b1;
        end else begin
            ack_now_s = {N_CPU{1'b0}};
        end
    end

    // Bus outputs are set up for the phase being entered at this cen
    always_comb begin
        va_d        = va_q;
        vd_out_d    = vd_out_q;
        dev_csn_d   = dev_csn_q;
        vwe_n_d     = vwe_n_q;
        v_c_d       = v_c_q;
        cpu_ack_d   = {N_CPU{1'b0}};
        cpu_rdata_d = cpu_rdata_q;
        armed_d     = armed_q;
        active_d    = active_q;
        we_lat_d    = we_lat_q;
        cs_lat_d    = cs_lat_q;
        if (cen) begin
            cpu_ack_d = ack_now_s;
            if (|ack_now_s) begin
                cpu_rdata_d = we_lat_q ? DATA_IDLE : rd_sel_s;
            end else begin
                cpu_rdata_d = cpu_rdata_q;
            end
            // Ack disarms; a low request re-arms
            for (int k = 0; k < N_CPU; k++) begin
                if (ack_now_s[k]) begin
                    armed_d[k] = 1'b0;
                end else if (!cpu_req[k]) begin
                    armed_d[k] = 1'b1;
                end else begin
                    armed_d[k] = armed_q[k];
                end
            end
            case (slot_kind_nxt_s)
                SLOT_CPU: begin
                    v_c_d = 1'b0;
                    if (phase_nxt_s == PH_SETUP) begin
                        vwe_n_d = 1'b1;
                        if (grant_s) begin
                            active_d  = 1'b1;
                            we_lat_d  = cpu_we[cpu_idx_nxt_s];
                            cs_lat_d  = cs_pick_s;
                            va_d      = cpu_addr[cpu_idx_nxt_s*AW +: AW];
                            vd_out_d  = cpu_we[cpu_idx_nxt_s] ?
                                        cpu_wdata[cpu_idx_nxt_s*DW +: DW] : DATA_IDLE;
                            dev_csn_d = ~cs_pick_s;
                        end else begin
                            active_d  = 1'b0;
                            dev_csn_d = CSN_IDLE;
                        end
                    end else begin
                        vwe_n_d = active_q ? ~we_lat_q : 1'b1;
                    end
                end
                SLOT_VID: begin
                    v_c_d     = 1'b1;
                    dev_csn_d = CSN_IDLE;
                    vwe_n_d   = 1'b1;
                    active_d  = 1'b0;
                end
                default: begin
                    v_c_d     = 1'b1;
                    dev_csn_d = CSN_IDLE;
                    vwe_n_d   = 1'b1;
                    active_d  = 1'b0;
                end
            endcase
        end else begin
            cpu_ack_d = {N_CPU{1'b0}};
        end
    end

    // Output and access registers; ack clears on every clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            va_q        <= {AW{1'b0}};
            vd_out_q    <= DATA_IDLE;
            dev_csn_q   <= CSN_IDLE;
            vwe_n_q     <= 1'b1;
            v_c_q       <= 1'b1;
            cpu_ack_q   <= {N_CPU{1'b0}};
            cpu_rdata_q <= DATA_IDLE;
            armed_q     <= {N_CPU{1'b1}};
            active_q    <= 1'b0;
            we_lat_q    <= 1'b0;
            cs_lat_q    <= {N_DEV{1'b0}};
        end else begin
            va_q        <= va_d;
            vd_out_q    <= vd_out_d;
            dev_csn_q   <= dev_csn_d;
            vwe_n_q     <= vwe_n_d;
            v_c_q       <= v_c_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            armed_q     <= armed_d;
            active_q    <= active_d;
            we_lat_q    <= we_lat_d;
            cs_lat_q    <= cs_lat_d;
        end
    end

    assign va        = va_q;
    assign vd_out    = vd_out_q;
    assign dev_csn   = dev_csn_q;
    assign vwe_n     = vwe_n_q;
    assign v_c       = v_c_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_snk_vbus_arbiter.sv
// Self-checking bench for snk_vbus_arbiter: frame-position model compared every clk,
// plus directed accesses with literal expectations.
module tb_snk_vbus_arbiter;

    localparam int N_CPU   = 2;
    localparam int N_DEV   = 3;
    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int CEN_DIV = 4;
`ifdef SNK_VBUS_VBLANK_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   cen = 1'b0;
    logic                   vblank = 1'b0;
    logic [N_CPU-1:0]       cpu_req = '0;
    logic [N_CPU-1:0]       cpu_we = '0;
    logic [N_CPU*AW-1:0]    cpu_addr = '0;
    logic [N_CPU*DW-1:0]    cpu_wdata = '0;
    logic [N_CPU*N_DEV-1:0] cpu_cs = '0;
    logic [N_DEV*DW-1:0]    dev_rdata = '0;
    logic [N_CPU-1:0]       cpu_ack;
    logic [DW-1:0]          cpu_rdata;
    logic [AW-1:0]          va;
    logic [DW-1:0]          vd_out;
    logic [N_DEV-1:0]       dev_csn;
    logic                   vwe_n;
    logic                   v_c;

    int checks = 0;
    int errors = 0;
    int cen_cnt = 0;

    snk_vbus_arbiter #(.N_CPU(N_CPU), .N_DEV(N_DEV), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cen(cen), .vblank(vblank),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .dev_rdata(dev_rdata), .va(va), .vd_out(vd_out),
        .dev_csn(dev_csn), .vwe_n(vwe_n), .v_c(v_c)
    );

    initial forever #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            cen = (cen_cnt == CEN_DIV - 1);
            cen_cnt = (cen_cnt + 1) % CEN_DIV;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame = list of 2*N_CPU slots (even = VID, odd = CPU s/2), each SETUP then STROBE.
    int               m_s, m_ph, tick;
    bit               m_act, m_we;
    logic [2:0]       m_cs;
    logic [N_CPU-1:0] m_armed;
    logic [AW-1:0]    e_va;
    logic [DW-1:0]    e_vd, e_rdata;
    logic [N_DEV-1:0] e_csn;
    logic             e_vwe_n, e_v_c;
    logic [N_CPU-1:0] e_ack;

    function automatic int lowest_dev(input logic [2:0] cs);
        for (int i = 0; i < N_DEV; i++) if (cs[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_s = 0; m_ph = 0; tick = 0; m_act = 0; m_we = 0; m_cs = '0;
        m_armed = '1; e_va = '0; e_vd = 8'hFF; e_rdata = 8'hFF;
        e_csn = 3'b111; e_vwe_n = 1'b1; e_v_c = 1'b1; e_ack = '0;
    endtask

    initial begin : model_p
        int k, d;
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
            end else begin
                e_ack = '0;
                if (cen) begin
                    k = m_s / 2;
                    if (m_s % 2 == 1 && m_ph == 1 && m_act) begin
                        e_ack[k] = 1'b1;
                        d = lowest_dev(m_cs);
                        e_rdata = (m_we || d < 0) ? 8'hFF : dev_rdata[d*DW +: DW];
                        m_armed[k] = 1'b0;
                    end
                    for (int j = 0; j < N_CPU; j++)
                        if (!e_ack[j] && !cpu_req[j]) m_armed[j] = 1'b1;
                    tick++;
                    if (m_ph == 0) begin
                        m_ph = 1;
                    end else begin
                        m_ph = 0;
                        if (m_s % 2 == 1 && BURST && vblank) m_s = (m_s + 2) % (2 * N_CPU);
                        else m_s = (m_s + 1) % (2 * N_CPU);
                    end
                    k = m_s / 2;
                    if (m_s % 2 == 0) begin
                        e_v_c = 1'b1; e_csn = 3'b111; e_vwe_n = 1'b1; m_act = 0;
                    end else if (m_ph == 0) begin
                        e_v_c = 1'b0; e_vwe_n = 1'b1;
                        if (cpu_req[k] && m_armed[k]) begin
                            m_act = 1; m_we = cpu_we[k]; m_cs = cpu_cs[k*N_DEV +: N_DEV];
                            e_va = cpu_addr[k*AW +: AW];
                            e_vd = m_we ? cpu_wdata[k*DW +: DW] : 8'hFF;
                            d = lowest_dev(m_cs);
                            e_csn = 3'b111;
                            if (d >= 0) e_csn[d] = 1'b0;
                        end else begin
                            m_act = 0; e_csn = 3'b111;
                        end
                    end else begin
                        e_vwe_n = m_act ? ~m_we : 1'b1;
                    end
                end
            end
        end
    end

    // Per-clk comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("va", va, e_va);
            check("vd_out", vd_out, e_vd);
            check("dev_csn", dev_csn, e_csn);
            check("vwe_n", vwe_n, e_vwe_n);
            check("v_c", v_c, e_v_c);
            check("cpu_ack", cpu_ack, e_ack);
            if (e_ack != '0) check("cpu_rdata", cpu_rdata, e_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_cpu(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [N_DEV-1:0] cs);
        cpu_we[k] = we;
        cpu_addr[k*AW +: AW] = a;
        cpu_wdata[k*DW +: DW] = wd;
        cpu_cs[k*N_DEV +: N_DEV] = cs;
    endtask

    task automatic wait_setup(input logic [N_DEV-1:0] csn_exp);
        bit found = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!v_c && dev_csn == csn_exp) begin
                found = 1;
                break;
            end
        end
        check("setup_seen", found, 1);
    endtask

    task automatic run_access(input int k, input bit drop, output int t, output int lo,
                              output int sel, output logic [DW-1:0] rd);
        bit got = 0;
        t = -1; lo = 0; sel = 0; rd = 8'h00;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cpu_ack[k]) begin
                got = 1; t = tick; rd = cpu_rdata;
                if (drop) cpu_req[k] = 1'b0;
                break;
            end
            if (!vwe_n) lo++;
            if (dev_csn != 3'b111) sel++;
        end
        check("ack_seen", got, 1);
    endtask

    initial begin
        int t, t2, lo, sel, cnt;
        logic [DW-1:0] rd;
        repeat (3) @(negedge clk);
        // reset values
        check("rst_va", va, 12'h000);
        check("rst_vd", vd_out, 8'hFF);
        check("rst_csn", dev_csn, 3'b111);
        check("rst_vwe_n", vwe_n, 1'b1);
        check("rst_v_c", v_c, 1'b1);
        check("rst_ack", cpu_ack, 2'b00);
        check("rst_rdata", cpu_rdata, 8'hFF);

        // CPU0 write right after reset
        set_cpu(0, 1'b1, 12'h3A5, 8'h5C, 3'b010);
        cpu_req[0] = 1'b1;
        reset = 1'b0;
        wait_setup(3'b101);
        check("wr_va", va, 12'h3A5);
        check("wr_vd", vd_out, 8'h5C);
        check("wr_setup_vwe", vwe_n, 1'b1);
        run_access(0, 1'b1, t, lo, sel, rd);
        check("wr_vwe_low_clks", lo, CEN_DIV);
        check("wr_ack_tick", t, 4);
        @(negedge clk);
        check("wr_ack_width", cpu_ack, 2'b00);

        // CPU1 read from device 0
        dev_rdata = {8'h33, 8'h22, 8'hC3};
        set_cpu(1, 1'b0, 12'h123, 8'h00, 3'b001);
        cpu_req[1] = 1'b1;
        run_access(1, 1'b1, t, lo, sel, rd);
        check("rd_rdata", rd, 8'hC3);
        check("rd_vwe_low_clks", lo, 0);

        // reset in the middle of a CPU0 access, then both requesting
        set_cpu(0, 1'b1, 12'h3A5, 8'h5C, 3'b010);
        cpu_req = 2'b11;
        wait_setup(3'b101);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_va", va, 12'h000);
        check("mid_rst_csn", dev_csn, 3'b111);
        check("mid_rst_vwe_n", vwe_n, 1'b1);
        check("mid_rst_v_c", v_c, 1'b1);
        check("mid_rst_vd", vd_out, 8'hFF);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack != 2'b00) cnt++;
        end
        check("mid_rst_no_ack", cnt, 0);
        reset = 1'b0;
        run_access(0, 1'b0, t, lo, sel, rd);
        check("both_ack0_tick", t, 4);
        run_access(1, 1'b1, t, lo, sel, rd);
        check("both_ack1_tick", t, 8);
        check("both_rd1", rd, 8'hC3);

        // CPU0 held high after its ack: no re-service
        cnt = 0;
        repeat (12 * CEN_DIV) begin
            @(negedge clk);
            if (cpu_ack[0]) cnt++;
        end
        check("hold_no_reack", cnt, 0);
        cpu_req[0] = 1'b0;
        repeat (2 * CEN_DIV) @(negedge clk);

        // multi-hot select: lowest device wins
        set_cpu(0, 1'b1, 12'h0F0, 8'hA5, 3'b110);
        cpu_req[0] = 1'b1;
        wait_setup(3'b101);
        check("multi_va", va, 12'h0F0);
        run_access(0, 1'b1, t, lo, sel, rd);
        check("multi_vwe_low_clks", lo, CEN_DIV);

        // read with no device selected
        set_cpu(1, 1'b0, 12'h7FF, 8'h00, 3'b000);
        cpu_req[1] = 1'b1;
        run_access(1, 1'b1, t, lo, sel, rd);
        check("nocs_rdata", rd, 8'hFF);
        check("nocs_sel_clks", sel, 0);

        // request dropped after SETUP still completes
        set_cpu(0, 1'b0, 12'h456, 8'h00, 3'b100);
        cpu_req[0] = 1'b1;
        wait_setup(3'b011);
        cpu_req[0] = 1'b0;
        run_access(0, 1'b1, t, lo, sel, rd);
        check("drop_rdata", rd, 8'h33);

`ifdef SNK_VBUS_VBLANK_BURST_EN
        // vblank burst: back-to-back CPU slots
        begin
            int k1, vc_hi;
            bit got;
            vblank = 1'b1;
            set_cpu(0, 1'b1, 12'h111, 8'h11, 3'b001);
            set_cpu(1, 1'b1, 12'h222, 8'h22, 3'b010);
            cpu_req = 2'b11;
            got = 0; k1 = 0; t = -1;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                if (cpu_ack != 2'b00) begin
                    got = 1; t = tick; k1 = cpu_ack[1] ? 1 : 0;
                    cpu_req[k1] = 1'b0;
                    break;
                end
            end
            check("burst_ack1_seen", got, 1);
            vc_hi = 0;
            run_access(1 - k1, 1'b1, t2, lo, sel, rd);
            for (int n = 0; n < 1; n++) vc_hi = vc_hi + (v_c ? 1 : 0);
            check("burst_ack_gap", t2 - t, 2);
            check("burst_v_c_after", vc_hi, 0);
            vblank = 1'b0;
            cpu_req = 2'b00;
        end
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
